fp_to_int_pipelined: RTL and testbench

Three-stage pipelined converter from single-precision float (float_point_num) to a signed fixed-point integer. It is the decode side of the FP summator datapath: the summator packs its results into float_point_num, and this block unpacks them back to two's-complement for integer consumers. The interface is a valid/ready stream on both sides, with full-pipeline stall on backpressure. Each result carries a 2-bit conversion status.

---
 rtl/float_types_pkg.sv | 33 +++
 rtl/fp2int_align_stage.sv | 44 ++++
 rtl/fp_to_int_pipelined.sv | 174 +++++++++++++++++
 tb/tb_fp_to_int_pipelined.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/float_types_pkg.sv
// Shared single-precision float types, conversion status codes and helpers.
package float_types_pkg;

  localparam int unsigned FP_BIAS    = 127;
  localparam int unsigned FP_EXP_MAX = 255;
  localparam int unsigned FP_MANT_W  = 23;

  typedef struct packed {
    logic                 sign;
    logic [7:0]           exp;
    logic [FP_MANT_W-1:0] mant;
  } float_point_num;

  typedef enum logic [1:0] {
    CVT_EXACT   = 2'b00,
    CVT_INEXACT = 2'b01,
    CVT_OVF     = 2'b10,
    CVT_NAN     = 2'b11
  } cvt_status_t;

  // Operand class decided in stage 1 and carried down the pipe
  typedef enum logic [1:0] {
    FP_CLS_NORM,
    FP_CLS_ZERO,
    FP_CLS_INF,
    FP_CLS_NAN
  } fp_cls_t;

  function automatic logic is_nan(input float_point_num f);
    return (f.exp == 8'(FP_EXP_MAX)) && (f.mant != '0);
  endfunction

endpackage

// File: rtl/fp2int_align_stage.sv
// Stage-2 aligner: shifts the 24-bit significand by e-23 into an INT_W+1 bit
// magnitude, extracting guard and sticky bits on right shifts.
module fp2int_align_stage
  import float_types_pkg::*;
#(
  parameter int unsigned INT_W = 32
) (
  input  logic [FP_MANT_W:0] sig_i,
  input  logic signed [9:0]  e_i,
  output logic [INT_W:0]     mag_o,
  output logic               g_o,
  output logic               s_o
);

  localparam int unsigned MW = INT_W + 1;
  // Largest shift whose leading one still lands inside the magnitude
  localparam logic signed [9:0] SH_MAX = 10'(INT_W) - 10'sd23;

  logic signed [9:0] w_sh;
  logic [9:0]        w_rsh;
  logic [47:0]       w_wide;

  // Left shift, right shift with guard/sticky, or saturate the magnitude
  always_comb begin
    w_sh   = e_i - 10'sd23;
    w_rsh  = 10'(-w_sh);
    w_wide = {sig_i, 24'd0} >> w_rsh;
    mag_o  = '0;
    g_o    = 1'b0;
    s_o    = 1'b0;
    if (w_sh > SH_MAX) begin
      mag_o = '1;
    end else if (w_sh >= 10'sd0) begin
      mag_o = MW'(sig_i) << 10'(w_sh);
    end else if (w_sh <= -10'sd25) begin
      s_o = 1'b1;
    end else begin
      mag_o = MW'(w_wide[47:24]);
      g_o   = w_wide[23];
      s_o   = |w_wide[22:0];
    end
  end

endmodule

// File: rtl/fp_to_int_pipelined.sv
// Three-stage float -> signed fixed-point converter with valid/ready stall.
// Define FP2INT_RNE_EN for round-to-nearest-even; default truncates toward zero.
module fp_to_int_pipelined
  import float_types_pkg::*;
#(
  parameter int unsigned INT_W  = 32,
  parameter int unsigned FRAC_W = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  float_point_num   a_i,
  input  logic             vld_i,
  output logic             rdy_o,
  output logic [INT_W-1:0] int_o,
  output logic             vld_o,
  input  logic             rdy_i,
  output logic [1:0]       cvt_status_o
);

  localparam int unsigned MW = INT_W + 1;
  localparam logic [MW:0] LIM_N = (MW+1)'(1) << (INT_W - 1);
  localparam logic [MW:0] LIM_P = LIM_N - (MW+1)'(1);
  localparam logic [INT_W-1:0] MAXP = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] MINN = {1'b1, {(INT_W-1){1'b0}}};

  logic              r_s1_vld, r_s1_sign, r_s1_zinex;
  fp_cls_t           r_s1_cls;
  logic [FP_MANT_W:0] r_s1_sig;
  logic signed [9:0] r_s1_e;

  logic              r_s2_vld, r_s2_sign, r_s2_g, r_s2_s;
  fp_cls_t           r_s2_cls;
  logic [INT_W:0]    r_s2_mag;

  logic              w_ld1, w_ld2, w_ld3;
  fp_cls_t           w_cls;
  logic signed [9:0] w_e;
  logic [INT_W:0]    w_mag;
  logic              w_g, w_s;
  logic [MW:0]       w_mag_r;
  logic              w_ovf;
  logic [INT_W-1:0]  w_res;
  cvt_status_t       w_st;

  // Each stage loads when the stage after it is empty or moving on
  always_comb begin
    w_ld3 = !vld_o || rdy_i;
    w_ld2 = !r_s2_vld || w_ld3;
    w_ld1 = !r_s1_vld || w_ld2;
  end

  assign rdy_o = w_ld1;

  // Stage 1: classify operand and compute unbiased, fraction-adjusted exponent
  always_comb begin
    w_cls = FP_CLS_NORM;
    w_e   = 10'(a_i.exp) - 10'(FP_BIAS) + 10'(FRAC_W);
    if (is_nan(a_i))                        w_cls = FP_CLS_NAN;
    else if (a_i.exp == 8'(FP_EXP_MAX))     w_cls = FP_CLS_INF;
    else if (a_i.exp == '0)                 w_cls = FP_CLS_ZERO;
  end

  // Stage 1 register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_vld   <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_zinex <= 1'b0;
      r_s1_cls   <= FP_CLS_NORM;
      r_s1_sig   <= '0;
      r_s1_e     <= '0;
    end else if (w_ld1) begin
      r_s1_vld <= vld_i;
      if (vld_i) begin
        r_s1_sign  <= a_i.sign;
        r_s1_zinex <= (a_i.mant != '0);
        r_s1_cls   <= w_cls;
        r_s1_sig   <= {1'b1, a_i.mant};
        r_s1_e     <= w_e;
      end
    end
  end

  fp2int_align_stage #(.INT_W(INT_W)) u_align (
    .sig_i (r_s1_sig),
    .e_i   (r_s1_e),
    .mag_o (w_mag),
    .g_o   (w_g),
    .s_o   (w_s)
  );

  // Stage 2 register; zero/denormal collapses to magnitude 0 with sticky = mant!=0
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s2_vld  <= 1'b0;
      r_s2_sign <= 1'b0;
      r_s2_cls  <= FP_CLS_NORM;
      r_s2_mag  <= '0;
      r_s2_g    <= 1'b0;
      r_s2_s    <= 1'b0;
    end else if (w_ld2) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_sign <= r_s1_sign;
        r_s2_cls  <= r_s1_cls;
        if (r_s1_cls == FP_CLS_ZERO) begin
          r_s2_mag <= '0;
          r_s2_g   <= 1'b0;
          r_s2_s   <= r_s1_zinex;
        end else begin
          r_s2_mag <= w_mag;
          r_s2_g   <= w_g;
          r_s2_s   <= w_s;
        end
      end
    end
  end

`ifdef FP2INT_RNE_EN
  logic w_inc;
  // Stage 3 rounding: nearest, ties to even
  always_comb begin
    w_inc   = r_s2_g && (r_s2_s || r_s2_mag[0]);
    w_mag_r = {1'b0, r_s2_mag} + (MW+1)'(w_inc);
  end
`else
  // Stage 3 rounding: truncate toward zero
  always_comb begin
    w_mag_r = {1'b0, r_s2_mag};
  end
`endif

  // Stage 3: saturate, apply sign, pick status by priority
  always_comb begin
    w_ovf = r_s2_sign ? (w_mag_r > LIM_N) : (w_mag_r > LIM_P);
    w_res = '0;
    w_st  = CVT_EXACT;
    case (r_s2_cls)
      FP_CLS_NAN: begin
        w_res = MAXP;
        w_st  = CVT_NAN;
      end
      FP_CLS_INF: begin
        w_res = r_s2_sign ? MINN : MAXP;
        w_st  = CVT_OVF;
      end
      default: begin
        if (w_ovf) begin
          w_res = r_s2_sign ? MINN : MAXP;
          w_st  = CVT_OVF;
        end else begin
          w_res = r_s2_sign ? INT_W'(~w_mag_r + (MW+1)'(1)) : INT_W'(w_mag_r);
          w_st  = (r_s2_g || r_s2_s) ? CVT_INEXACT : CVT_EXACT;
        end
      end
    endcase
  end

  // Output register; held while the consumer stalls
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_o        <= 1'b0;
      int_o        <= '0;
      cvt_status_o <= 2'b00;
    end else if (w_ld3) begin
      vld_o <= r_s2_vld;
      if (r_s2_vld) begin
        int_o        <= w_res;
        cvt_status_o <= w_st;
      end
    end
  end

endmodule

// File: tb/tb_fp_to_int_pipelined.sv
// Testbench for fp_to_int_pipelined: vector table plus scoreboard, stall and reset sequences.
module tb_fp_to_int_pipelined;
  import float_types_pkg::*;

  logic           clk = 1'b0;
  logic           rst_ni;
  float_point_num a_i;
  logic           vld_i, rdy_i;
  logic           rdy_o, vld_o, f_rdy, f_vld;
  logic [31:0]    int_o, f_int;
  logic [1:0]     st_o, f_st;

  always #5 clk = ~clk;

  fp_to_int_pipelined #(.INT_W(32), .FRAC_W(0)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .a_i(a_i), .vld_i(vld_i), .rdy_o(rdy_o),
    .int_o(int_o), .vld_o(vld_o), .rdy_i(rdy_i), .cvt_status_o(st_o));

  fp_to_int_pipelined #(.INT_W(32), .FRAC_W(8)) dut_f (
    .clk_i(clk), .rst_ni(rst_ni), .a_i(a_i), .vld_i(vld_i), .rdy_o(f_rdy),
    .int_o(f_int), .vld_o(f_vld), .rdy_i(rdy_i), .cvt_status_o(f_st));

`ifdef FP2INT_RNE_EN
  localparam logic [31:0] R35 = 32'd4;
  localparam logic [31:0] R15 = 32'd2;
`else
  localparam logic [31:0] R35 = 32'd3;
  localparam logic [31:0] R15 = 32'd1;
`endif

  typedef struct { logic [31:0] a; logic [31:0] r; logic [1:0] st; } vec_t;
  typedef struct { logic [31:0] r; logic [1:0] st; int t; bit lat; } exp_t;

  localparam int NV = 20;
  vec_t  vt[NV];
  vec_t  bp[6];
  exp_t  q[$];
  exp_t  m_e;
  int    n_cmp = 0, n_bad = 0, n_acc = 0, n_rx = 0, cyc = 0;
  logic  prev_stall = 1'b0;
  logic [31:0] prev_int;
  logic [1:0]  prev_st;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard consumer and stall-stability checker
  always @(negedge clk) begin
    if (!rst_ni) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_vld", 32'(vld_o), 32'd1);
        check("stall_int", int_o, prev_int);
        check("stall_st", 32'(st_o), 32'(prev_st));
      end
      if (vld_o && rdy_i) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_output: got %0h, required none", int_o);
        end else begin
          m_e = q.pop_front();
          check("int_o", int_o, m_e.r);
          check("status", 32'(st_o), 32'(m_e.st));
          if (m_e.lat) check("latency", 32'(cyc - m_e.t), 32'd3);
          n_rx++;
        end
      end
      prev_stall = vld_o && !rdy_i;
      prev_int   = int_o;
      prev_st    = st_o;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] r, input logic [1:0] st, input bit lat);
    bit acc = 1'b0;
    int n = 0;
    a_i = a; vld_i = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      if (rdy_o) begin
        acc = 1'b1;
        q.push_back('{r, st, cyc, lat});
        n_acc++;
      end
      @(posedge clk); #1;
      n++;
    end
    vld_i = 1'b0;
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: got no accept, required accept of %0h", a);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk); n++;
    end
    #1;
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int c0, acc0, rx0, n;
    logic [31:0] held;
    vt[0]  = '{32'h3F800000, 32'h00000001, 2'b00};
    vt[1]  = '{32'hC0200000, 32'hFFFFFFFE, 2'b01};
    vt[2]  = '{32'h40600000, R35,          2'b01};
    vt[3]  = '{32'h4F000000, 32'h7FFFFFFF, 2'b10};
    vt[4]  = '{32'hCF000000, 32'h80000000, 2'b00};
    vt[5]  = '{32'h7F800000, 32'h7FFFFFFF, 2'b10};
    vt[6]  = '{32'hFF800000, 32'h80000000, 2'b10};
    vt[7]  = '{32'h7FC00000, 32'h7FFFFFFF, 2'b11};
    vt[8]  = '{32'h00000001, 32'h00000000, 2'b01};
    vt[9]  = '{32'h80000000, 32'h00000000, 2'b00};
    vt[10] = '{32'h3F000000, 32'h00000000, 2'b01};
    vt[11] = '{32'h4EFFFFFF, 32'h7FFFFF80, 2'b00};
    vt[12] = '{32'hCF000001, 32'h80000000, 2'b10};
    vt[13] = '{32'h3FC00000, R15,          2'b01};
    vt[14] = '{32'h00000000, 32'h00000000, 2'b00};
    vt[15] = '{32'h42F6E979, 32'h0000007B, 2'b01};
    vt[16] = '{32'h33800000, 32'h00000000, 2'b01};
    vt[17] = '{32'h4B000001, 32'h00800001, 2'b00};
    vt[18] = '{32'hCB7FFFFF, 32'hFF000001, 2'b00};
    vt[19] = '{32'hFFC00000, 32'h7FFFFFFF, 2'b11};
    bp[0]  = '{32'h3F800000, 32'h00000001, 2'b00};
    bp[1]  = '{32'h40000000, 32'h00000002, 2'b00};
    bp[2]  = '{32'h40400000, 32'h00000003, 2'b00};
    bp[3]  = '{32'hBF800000, 32'hFFFFFFFF, 2'b00};
    bp[4]  = '{32'h42C80000, 32'h00000064, 2'b00};
    bp[5]  = '{32'hC0E00000, 32'hFFFFFFF9, 2'b00};

    rst_ni = 1'b0; vld_i = 1'b0; rdy_i = 1'b0; a_i = '0;
    #12;
    check("rst_vld_o", 32'(vld_o), 32'd0);
    check("rst_int_o", int_o, 32'd0);
    check("rst_status", 32'(st_o), 32'd0);
    @(posedge clk); #3 rst_ni = 1'b1;
    @(posedge clk); #1;
    check("rdy_after_reset", 32'(rdy_o), 32'd1);

    // Table vectors streamed back to back at full rate
    rdy_i = 1'b1;
    c0 = cyc;
    for (int i = 0; i < NV; i++) send(vt[i].a, vt[i].r, vt[i].st, 1'b1);
    check("throughput", 32'(cyc - c0), 32'(NV));
    drain();

    // Fractional format: 1.5 with FRAC_W=8
    send(32'h3FC00000, R15, 2'b01, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("frac_vld", 32'(f_vld), 32'd1);
    check("frac_int", f_int, 32'h00000180);
    check("frac_status", 32'(f_st), 32'd0);
    drain();

    // Backpressure: fill with consumer stalled, then release with random ready
    @(posedge clk); #1;
    rdy_i = 1'b0;
    acc0 = n_acc; rx0 = n_rx;
    fork
      begin
        for (int i = 0; i < 6; i++) send(bp[i].a, bp[i].r, bp[i].st, 1'b0);
      end
      begin
        repeat (8) @(posedge clk);
        #2;
        check("bp_accepts", 32'(n_acc - acc0), 32'd3);
        check("bp_rdy_o", 32'(rdy_o), 32'd0);
        check("bp_vld_o", 32'(vld_o), 32'd1);
        check("bp_hold_first", int_o, 32'd1);
        held = int_o;
        repeat (4) @(posedge clk);
        #2;
        check("bp_stable", int_o, held);
        check("bp_accepts_still", 32'(n_acc - acc0), 32'd3);
        n = 0;
        while ((q.size() != 0 || (n_acc - acc0) < 6) && n < 400) begin
          @(posedge clk); #1;
          rdy_i = 1'($urandom_range(0, 1));
          n++;
        end
        rdy_i = 1'b1;
      end
    join
    drain();
    check("bp_delivered", 32'(n_rx - rx0), 32'd6);

    // Asynchronous reset with three operands in flight
    send(32'h40000000, 32'd2, 2'b00, 1'b0);
    send(32'h40400000, 32'd3, 2'b00, 1'b0);
    send(32'hBF800000, 32'hFFFFFFFF, 2'b00, 1'b0);
    #1;
    check("pre_reset_vld", 32'(vld_o), 32'd1);
    rst_ni = 1'b0;
    q.delete();
    #1;
    check("async_rst_vld", 32'(vld_o), 32'd0);
    check("async_rst_int", int_o, 32'd0);
    check("async_rst_status", 32'(st_o), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_stale_vld", 32'(vld_o), 32'd0);
    end
    @(posedge clk); #1;
    send(32'h3F800000, 32'd1, 2'b00, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
